spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
SPI responder (slave) matching the team's spi_master: receives MOSI words from an external or looped-back master and returns a word on MISO in the same frame. SPI mode 0 (CPOL=0, CPHA=0). All pins are oversampled in the system clock domain, so there is no logic clocked by SCLK. Used for loopback verification of spi_master and as a command receiver for LCD/peripheral bring-up.

Parameters:
WIDTH, 8, bits per word (2..16)
MSB_FIRST, 1, 1 = MSB shifted first on both lines; 0 = LSB first

Ports:
clk  input  1  system clock; must be at least 8x SCLK frequency
rst  input  1  asynchronous active-high reset
sclk  input  1  SPI clock from master, asynchronous to clk
ss  input  1  slave select, active low, asynchronous
mosi  input  1  serial data from master, asynchronous
miso  output  1  serial data to master
miso_oe  output  1  MISO output enable; high only while a frame is active
tx_data  input  WIDTH  word to transmit; sampled at each word load
tx_ack  output  1  one-cycle pulse when tx_data has been captured
rx_data  output  WIDTH  last complete received word; held until the next word completes
rx_valid  output  1  one-cycle pulse when rx_data updates
frame_active  output  1  high while the synchronised SS is low
frame_err  output  1  one-cycle pulse when SS deasserts mid-word

Behaviour:
- Input synchronisers: two flops each on sclk, ss and mosi. A third flop on sclk and on ss provides edge detection.
- Synchroniser reset values: ss flops reset to 1, sclk and mosi flops reset to 0, so reset release never produces a false frame start.
- Pin-to-internal-event latency is 3 clk cycles.
- Reset state: all outputs 0 (miso=0, miso_oe=0, rx_data=0). FSM=IDLE, bit_cnt=0, shift registers 0. Reset is honoured at any time; a frame in progress is discarded with no rx_valid and no frame_err.
- FSM states: IDLE and ACTIVE.
- IDLE -> ACTIVE on a synchronised SS falling edge:
  - tx shift register <= tx_data; tx_ack pulses in the same cycle.
  - bit_cnt <= 0; miso <= first bit (tx_data[WIDTH-1] if MSB_FIRST, else tx_data[0]).
  - miso_oe <= 1; frame_active <= 1.
- ACTIVE, SCLK rising edge (sample):
  - Shift mosi into the rx shift register (into the LSB if MSB_FIRST, else into the MSB).
  - If bit_cnt == WIDTH-1: rx_data <= the completed word including the current bit; rx_valid pulses in the next cycle; bit_cnt <= 0; set word_done.
  - Otherwise bit_cnt <= bit_cnt + 1.
- ACTIVE, SCLK falling edge (shift out):
  - If word_done: reload the tx shift register from tx_data, pulse tx_ack, drive its first bit on miso, clear word_done.
  - Otherwise shift the tx register and drive the next bit on miso.
  - A frame can carry any number of back-to-back words.
- ACTIVE -> IDLE on a synchronised SS rising edge:
  - miso_oe <= 0, miso <= 0, frame_active <= 0.
  - If bit_cnt != 0, frame_err pulses and the partial word is dropped (rx_data keeps its old value).
  - bit_cnt <= 0; word_done cleared.
- SS edge and SCLK edge in the same cycle: the SS edge takes priority and the SCLK edge is ignored.
- SCLK edges while in IDLE are ignored. MOSI is don't-care in IDLE.
- rx_valid has no backpressure. A consumer that misses the pulse loses the word, and rx_data is overwritten by the next word.
- bit_cnt width is clog2(WIDTH). Wrap-around happens only through the explicit reset to 0 at WIDTH-1.

Test Plan:
1. WIDTH=8, tx_data=0x3C, one frame with master sending 0xA5 -> rx_data=0xA5 with exactly one rx_valid pulse; MISO sampled on master rising edges = 0,0,1,1,1,1,0,0; one tx_ack at frame start.
2. One frame carrying 0x01 then 0x80, tx_data changed from 0x3C to 0xC3 between words -> two rx_valid pulses with rx_data 0x01 then 0x80; master receives 0x3C then 0xC3; two tx_ack pulses.
3. SS raised after 5 bits -> frame_err pulses once, no rx_valid, rx_data unchanged; a following full frame of 0xFF -> rx_data=0xFF and no frame_err.
4. rst asserted after 4 bits of a frame, released, then a clean frame of 0x5A -> all outputs 0 during reset; after release rx_data=0x5A with one rx_valid and no frame_err.
5. SCLK toggled 16 times with SS held high -> no rx_valid, tx_ack or frame_err; miso_oe=0 and frame_active=0 throughout.
6. MSB_FIRST=0, master sends 0x01 LSB-first, tx_data=0x80 -> rx_data=0x01; MISO sequence = 0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder. All SPI pins are oversampled in the clk domain;
// nothing is clocked by SCLK. Receives MOSI words and returns tx_data words
// on MISO within the same frame; frames may carry back-to-back words.
module spi_slave_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ack,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_active,
    output logic             frame_err
);

    localparam int               CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       sclk_q;
    logic [2:0]       ss_q;
    logic [1:0]       mosi_q;
    logic             sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic             start, stop, sample, shift;
    logic [CNT_W-1:0] bit_cnt;
    logic             word_done;
    logic [WIDTH-1:0] tx_sr, tx_shifted;
    logic [WIDTH-1:0] rx_sr, rx_next;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Two-flop synchronisers plus a third flop on sclk/ss for edge detection;
    // ss resets high so reset release never looks like a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_q[1] & ss_q[2];
    assign ss_rise   = ss_q[1] & ~ss_q[2];

    assign tx_shifted = MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
    assign rx_next    = MSB_FIRST ? {rx_sr[WIDTH-2:0], mosi_q[1]}
                                  : {mosi_q[1], rx_sr[WIDTH-1:1]};

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle action strobes; SS edges win over SCLK edges.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        stop      = 1'b0;
        sample    = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt = ACTIVE;
                    start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    stop      = 1'b1;
                end else if (sclk_rise) begin
                    sample = 1'b1;
                end else if (sclk_fall) begin
                    shift = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers, bit counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr        <= '0;
            rx_sr        <= '0;
            rx_data      <= '0;
            bit_cnt      <= '0;
            word_done    <= 1'b0;
            miso         <= 1'b0;
            miso_oe      <= 1'b0;
            frame_active <= 1'b0;
            tx_ack       <= 1'b0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            tx_ack    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (start) begin
                tx_sr        <= tx_data;
                tx_ack       <= 1'b1;
                miso         <= first_bit(tx_data);
                bit_cnt      <= '0;
                word_done    <= 1'b0;
                miso_oe      <= 1'b1;
                frame_active <= 1'b1;
            end else if (stop) begin
                miso         <= 1'b0;
                miso_oe      <= 1'b0;
                frame_active <= 1'b0;
                frame_err    <= (bit_cnt != '0);
                bit_cnt      <= '0;
                word_done    <= 1'b0;
            end else if (sample) begin
                rx_sr <= rx_next;
                if (bit_cnt == LAST) begin
                    rx_data   <= rx_next;
                    rx_valid  <= 1'b1;
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (shift) begin
                // After a completed word the falling edge starts the next word
                // rather than shifting past the end of the old one.
                if (word_done) begin
                    tx_sr     <= tx_data;
                    tx_ack    <= 1'b1;
                    miso      <= first_bit(tx_data);
                    word_done <= 1'b0;
                end else begin
                    tx_sr <= tx_shifted;
                    miso  <= first_bit(tx_shifted);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an MSB-first and an LSB-first instance share SCLK
// and MOSI but have separate slave selects. Expected rx words are queued by
// the stimulus and checked by a monitor on each rx_valid pulse.
module tb_spi_slave_rx;

    localparam time HALF = 80ns;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       ss_m = 1'b1, ss_l = 1'b1;
    logic [7:0] tx_m = '0, tx_l = '0;

    logic       miso_m, miso_oe_m, tx_ack_m, rx_valid_m, frame_active_m, frame_err_m;
    logic       miso_l, miso_oe_l, tx_ack_l, rx_valid_l, frame_active_l, frame_err_l;
    logic [7:0] rx_data_m, rx_data_l;

    int unsigned n_cmp = 0, n_err = 0;
    int unsigned ack_m = 0, val_m = 0, fe_m = 0;
    int unsigned ack_l = 0, val_l = 0, fe_l = 0;
    logic [7:0]  q_m[$], q_l[$];

    spi_slave_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss_m), .mosi(mosi),
        .miso(miso_m), .miso_oe(miso_oe_m), .tx_data(tx_m), .tx_ack(tx_ack_m),
        .rx_data(rx_data_m), .rx_valid(rx_valid_m),
        .frame_active(frame_active_m), .frame_err(frame_err_m)
    );

    spi_slave_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss_l), .mosi(mosi),
        .miso(miso_l), .miso_oe(miso_oe_l), .tx_data(tx_l), .tx_ack(tx_ack_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l),
        .frame_active(frame_active_l), .frame_err(frame_err_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected words on rx_valid and counts the pulse outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid_m) begin
                val_m++;
                if (q_m.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rx_m_unexpected: got 0x%0h expected no word", rx_data_m);
                end else chk("rx_data_m", 32'(rx_data_m), 32'(q_m.pop_front()));
            end
            if (rx_valid_l) begin
                val_l++;
                if (q_l.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rx_l_unexpected: got 0x%0h expected no word", rx_data_l);
                end else chk("rx_data_l", 32'(rx_data_l), 32'(q_l.pop_front()));
            end
            ack_m += 32'(tx_ack_m);  fe_m += 32'(frame_err_m);
            ack_l += 32'(tx_ack_l);  fe_l += 32'(frame_err_l);
        end
    end

    task automatic start_frame(input bit lsb);
        if (lsb) ss_l = 1'b0; else ss_m = 1'b0;
        #HALF;
        if (lsb) chk("frame_on_l", {30'd0, miso_oe_l, frame_active_l}, 32'd3);
        else     chk("frame_on_m", {30'd0, miso_oe_m, frame_active_m}, 32'd3);
    endtask

    task automatic bit_xfer(input bit lsb, input logic b, output logic m);
        if (sclk) sclk = 1'b0;
        mosi = b;
        #HALF;
        sclk = 1'b1;
        m = lsb ? miso_l : miso_m;
        #HALF;
    endtask

    task automatic end_frame();
        ss_m = 1'b1;
        ss_l = 1'b1;
        #HALF;
        sclk = 1'b0;
        #(4 * HALF);
    endtask

    task automatic spi_xfer(input bit lsb, input logic [31:0] bits, input int n,
                            input logic [7:0] tx_next, output logic [31:0] got);
        logic m;
        start_frame(lsb);
        got = '0;
        for (int i = 0; i < n; i++) begin
            bit_xfer(lsb, bits[n-1-i], m);
            got = {got[30:0], m};
            if (i == 4) begin
                if (lsb) tx_l = tx_next; else tx_m = tx_next;
            end
        end
        end_frame();
    endtask

    // Hard time limit so the run always reaches a summary.
    initial begin
        #500us;
        n_cmp++; n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        logic [31:0] got;
        logic        m;
        int unsigned a0, v0, e0, al0, vl0, el0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_m", {rx_data_m, miso_m, miso_oe_m, tx_ack_m, rx_valid_m, frame_active_m, frame_err_m}, 32'd0);
        chk("reset_l", {rx_data_l, miso_l, miso_oe_l, tx_ack_l, rx_valid_l, frame_active_l, frame_err_l}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single word 0xA5 in, 0x3C out
        tx_m = 8'h3C; a0 = ack_m; v0 = val_m; e0 = fe_m;
        q_m.push_back(8'hA5);
        spi_xfer(1'b0, 32'hA5, 8, 8'h3C, got);
        chk("t1_miso", got, 32'h3C);
        chk("t1_ack", ack_m - a0, 1);
        chk("t1_valid", val_m - v0, 1);
        chk("t1_err", fe_m - e0, 0);
        chk("t1_idle", {30'd0, miso_oe_m, frame_active_m}, 32'd0);

        // 2: two back-to-back words, tx_data changed between words
        tx_m = 8'h3C; a0 = ack_m; v0 = val_m; e0 = fe_m;
        q_m.push_back(8'h01); q_m.push_back(8'h80);
        spi_xfer(1'b0, 32'h0180, 16, 8'hC3, got);
        chk("t2_miso", got, 32'h3CC3);
        chk("t2_ack", ack_m - a0, 2);
        chk("t2_valid", val_m - v0, 2);
        chk("t2_err", fe_m - e0, 0);

        // 3: SS raised after 5 bits, then a clean 0xFF frame
        tx_m = 8'h00; v0 = val_m; e0 = fe_m;
        spi_xfer(1'b0, 32'h16, 5, 8'h00, got);
        chk("t3_err", fe_m - e0, 1);
        chk("t3_valid", val_m - v0, 0);
        chk("t3_rx_hold", 32'(rx_data_m), 32'h80);
        v0 = val_m; e0 = fe_m;
        q_m.push_back(8'hFF);
        spi_xfer(1'b0, 32'hFF, 8, 8'h00, got);
        chk("t3b_err", fe_m - e0, 0);
        chk("t3b_valid", val_m - v0, 1);
        chk("t3b_rx", 32'(rx_data_m), 32'hFF);

        // 4: reset after 4 bits, then a clean 0x5A frame
        e0 = fe_m;
        start_frame(1'b0);
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, 1'b1, m);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_reset", {rx_data_m, miso_m, miso_oe_m, tx_ack_m, rx_valid_m, frame_active_m, frame_err_m}, 32'd0);
        ss_m = 1'b1; sclk = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        v0 = val_m;
        q_m.push_back(8'h5A);
        spi_xfer(1'b0, 32'h5A, 8, 8'h00, got);
        chk("t4_valid", val_m - v0, 1);
        chk("t4_err", fe_m - e0, 0);
        chk("t4_rx", 32'(rx_data_m), 32'h5A);

        // 5: SCLK activity with both selects high
        a0 = ack_m; v0 = val_m; e0 = fe_m; al0 = ack_l; vl0 = val_l; el0 = fe_l;
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            #HALF;
            chk("t5_idle", {28'd0, miso_oe_m, frame_active_m, miso_oe_l, frame_active_l}, 32'd0);
        end
        #(2 * HALF);
        chk("t5_pulses", (ack_m - a0) + (val_m - v0) + (fe_m - e0) +
                         (ack_l - al0) + (val_l - vl0) + (fe_l - el0), 0);

        // 6: LSB-first instance, 0x01 in, 0x80 out
        tx_l = 8'h80; al0 = ack_l; vl0 = val_l; el0 = fe_l;
        q_l.push_back(8'h01);
        spi_xfer(1'b1, 32'h80, 8, 8'h80, got);
        chk("t6_miso", got, 32'h01);
        chk("t6_ack", ack_l - al0, 1);
        chk("t6_valid", val_l - vl0, 1);
        chk("t6_err", fe_l - el0, 0);

        repeat (5) @(negedge clk);
        chk("q_m_empty", q_m.size(), 0);
        chk("q_l_empty", q_l.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
